sseg_scan: RTL and testbench
============================

# sseg_scan

Four-digit multiplexed scan controller for the seven-segment display. It latches a 16-bit hex value and time-multiplexes it one nibble at a time. Each nibble feeds the hex-to-segment decoder, and the matching active-low anode is driven at the same time. Values are double-buffered, so a new value only reaches the display at a frame boundary and mid-frame tearing cannot occur.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz). Must be ≥ 2.
- `GUARD`, 16: cycles at the start of each slot with all anodes off (anti-ghosting). Must be < `REFRESH_DIV`; 0 disables the guard.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `value` in 16: hex value; digit 0 = `value[3:0]`, digit 3 = `value[15:12]`.
- `load` in 1: one-cycle strobe that captures `value` into the shadow register.
- `dig_en` in 4: per-digit enable. A 0 holds that anode off.
- `digit` out 4: nibble for the current slot, to the hex-to-segment decoder.
- `an` out 4: anodes, active-low, at most one bit low.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- State:
  - `div_cnt` counts 0..`REFRESH_DIV`-1.
  - `idx` (2 bits) is the current digit slot.
  - `shadow` and `active` are 16-bit registers.
  - `pending` is a 1-bit flag.
- Slot end: when `div_cnt == REFRESH_DIV-1`, `div_cnt` returns to 0 and `idx` increments mod 4. Scan order is 0,1,2,3,0,…
- Frame boundary: a slot end that occurs while `idx == 3`.
- Load handling:
  - On `load`: `shadow <= value`, `pending <= 1`.
  - At a frame boundary with `pending == 1`: `active <= shadow`, `pending <= 0`.
- `load` coincident with a frame boundary:
  - `active` takes the previous `shadow` (if `pending` was set).
  - `shadow` takes the new `value`.
  - `pending` ends at 1, so the new value displays one frame later.
- Back-to-back loads within one frame: the last one wins.
- `digit = active[4*idx +: 4]`.
- `an[i]` is low only when all of the following hold: `i == idx`, `dig_en[i] == 1`, `div_cnt >= GUARD`, and digit `i` is not suppressed (see Configuration). Otherwise it is high.
- `dig_en` is sampled every cycle and is not buffered.
- Reset (async, `rst_n` low), asserted at any time including mid-slot:
  - `div_cnt = 0`, `idx = 0`, `shadow = 0`, `active = 0`, `pending = 0`.
  - `digit = 4'h0`, `an = 4'hF`, `frame_tick = 0`.
- After reset release the scan restarts at digit 0 with a full guard interval.

## Timing
- All outputs are registered.
- `digit`, `an` and `idx` change on the same clock edge: the edge where `div_cnt` becomes 0.
- `an` stays 4'hF for cycles 0..`GUARD`-1 of each slot. The selected anode goes low on the edge where `div_cnt` becomes `GUARD`.
- `frame_tick` is high for the cycle after the boundary edge, i.e. the first cycle of the digit-0 slot. The new `active` value is visible on `digit` in that same cycle.
- Load-to-display latency: from the `load` edge to the start of the next frame. This is at most 4·`REFRESH_DIV` cycles, plus one frame if the load coincides with a boundary.
- Frame period is exactly 4·`REFRESH_DIV` cycles.

## Configuration
- `SSEG_LZ_BLANK_EN` defined: leading-zero blanking is active.
  - Digit i (i = 3..1) is suppressed (anode held high) when `active` nibbles i..3 are all zero.
  - Digit 0 is never suppressed, so 0 displays as a single "0".
  - Suppression is evaluated from `active`, so it also changes only at frame boundaries.
- Macro undefined: no suppression; every enabled digit is shown, including leading zeros.

## Test plan
- Reset values: hold `rst_n` low → `an = 4'hF`, `digit = 0`, `frame_tick = 0`. Release with `REFRESH_DIV=8`, `GUARD=2` → `an` follows 4'hF×2, 4'hE×6, 4'hF×2, 4'hD×6, … with period 32 cycles.
- Load and frame alignment: `load` with `value=16'hBEEF` at cycle 5 of slot 1 → `digit` stays 0 until the next `frame_tick`. It then shows F, E, E, B on slots 0..3.
- Load at boundary: `load` `16'h1234` at a boundary with `pending=0` → the next frame still shows the old value. The frame after that shows 4, 3, 2, 1.
- Digit mask: `dig_en=4'b0101` → `an[1]` and `an[3]` stay 1 throughout. Digits 0 and 2 still light normally.
- Leading-zero blanking (macro on): `active=16'h0042` → `an[3]` and `an[2]` are never low; digits 1 and 0 light. `16'h0000` → only digit 0 lights. Macro off → all four digits light.
- Mid-slot reset: assert `rst_n` low for 3 cycles during slot 2 → `an = 4'hF` immediately (asynchronous). `active = 0` after release. The scan restarts at digit 0 with the guard interval.

Source files
------------

// File: rtl/sseg_scan.sv
// +----------------------------------------------------------------------------+
// | sseg_scan: four-digit multiplexed seven-segment scan controller with a     |
// | double-buffered hex value. Define SSEG_LZ_BLANK_EN for leading-zero blank. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dig_en,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] C_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_GUARD = CW'(GUARD);

  logic [CW-1:0] r_div_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [15:0]   r_active;
  logic          r_pending;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [CW-1:0] w_div_nxt;
  logic [1:0]    w_idx_nxt;
  logic [15:0]   w_active_nxt;
  logic [15:0]   w_shadow_nxt;
  logic          w_pending_nxt;
  logic [3:0]    w_supp;
  logic          w_lit;
  logic [3:0]    w_an_nxt;
  logic [3:0]    w_digit_nxt;

  always_comb begin
    w_slot_end    = (r_div_cnt == C_LAST);
    w_frame_end   = w_slot_end && (r_idx == 2'd3);
    w_div_nxt     = w_slot_end ? '0 : r_div_cnt + 1'b1;
    w_idx_nxt     = w_slot_end ? r_idx + 2'd1 : r_idx;
    // A load on the boundary edge still swaps in the older shadow first.
    w_active_nxt  = (w_frame_end && r_pending) ? r_shadow : r_active;
    w_shadow_nxt  = load ? value : r_shadow;
    w_pending_nxt = load ? 1'b1 : (w_frame_end ? 1'b0 : r_pending);
  end

`ifdef SSEG_LZ_BLANK_EN
  always_comb begin
    w_supp    = 4'b0000;
    w_supp[1] = ~|w_active_nxt[15:4];
    w_supp[2] = ~|w_active_nxt[15:8];
    w_supp[3] = ~|w_active_nxt[15:12];
  end
`else
  always_comb begin
    w_supp = 4'b0000;
  end
`endif

  // Outputs are computed from next-state so they move on the same edge as idx.
  always_comb begin
    w_lit       = (w_div_nxt >= C_GUARD);
    w_an_nxt    = 4'hF;
    w_digit_nxt = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
    for (int i = 0; i < 4; i++) begin
      if ((w_idx_nxt == 2'(i)) && dig_en[i] && w_lit && !w_supp[i]) begin
        w_an_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_idx      <= 2'd0;
      r_shadow   <= 16'h0000;
      r_active   <= 16'h0000;
      r_pending  <= 1'b0;
      digit      <= 4'h0;
      an         <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      r_div_cnt  <= w_div_nxt;
      r_idx      <= w_idx_nxt;
      r_shadow   <= w_shadow_nxt;
      r_active   <= w_active_nxt;
      r_pending  <= w_pending_nxt;
      digit      <= w_digit_nxt;
      an         <= w_an_nxt;
      frame_tick <= w_frame_end;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan.sv
// +----------------------------------------------------------------------------+
// | tb_sseg_scan: frame-level scoreboard bench for sseg_scan (REFRESH_DIV=8,   |
// | GUARD=2). Revision: 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sseg_scan;

  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FR = 4 * RD;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] value  = 16'h0000;
  logic        load   = 1'b0;
  logic [3:0]  dig_en = 4'hF;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  sseg_scan #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .dig_en     (dig_en),
    .digit      (digit),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Expected anodes for cycle c of a frame showing v with enable mask en.
  function automatic logic [3:0] exp_an_f(input int c, input logic [15:0] v, input logic [3:0] en);
    int s, p;
    logic sup;
    logic [3:0] r;
    s   = (c / RD) % 4;
    p   = c % RD;
    sup = 1'b0;
    r   = 4'hF;
`ifdef SSEG_LZ_BLANK_EN
    if (s == 3)      sup = (v[15:12] == 4'h0);
    else if (s == 2) sup = (v[15:8] == 8'h00);
    else if (s == 1) sup = (v[15:4] == 12'h000);
`endif
    if (p >= GD && en[s] && !sup) r[s] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] exp_dig_f(input int c, input logic [15:0] v);
    logic [15:0] t;
    t = v >> (4 * ((c / RD) % 4));
    return t[3:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    repeat (3) step();
    checks++;
    if (an !== 4'hF) begin failures++; $display("FAIL reset_an actual=%h required=f", an); end
    checks++;
    if (digit !== 4'h0) begin failures++; $display("FAIL reset_digit actual=%h required=0", digit); end
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick actual=%b required=0", frame_tick); end
    rst_n = 1'b1;
    for (int c = 0; c < 2 * FR; c++) begin
      ea = exp_an_f(c, 16'h0000, 4'hF);
      checks++;
      if (an !== ea) begin failures++; $display("FAIL scan_an c=%0d actual=%h required=%h", c, an, ea); end
      checks++;
      if (digit !== 4'h0) begin failures++; $display("FAIL scan_digit c=%0d actual=%h required=0", c, digit); end
      checks++;
      if (frame_tick !== (c == FR)) begin
        failures++; $display("FAIL scan_tick c=%0d actual=%b required=%b", c, frame_tick, (c == FR));
      end
      step();
    end
  endtask

  task automatic test_load();
    logic [15:0] v;
    logic [3:0] ea;
    for (int k = 0; k < 2 * FR && frame_tick !== 1'b1; k++) step();
    checks++;
    if (frame_tick !== 1'b1) begin failures++; $display("FAIL load_wait_tick actual=%b required=1", frame_tick); end
    repeat (RD + 5) step();
    value = 16'hBEEF; load = 1'b1;
    step();
    load = 1'b0;
    exp_q.push_back(16'hBEEF);
    for (int c = RD + 6; c < FR; c++) begin
      checks++;
      if (digit !== 4'h0) begin failures++; $display("FAIL load_early_digit c=%0d actual=%h required=0", c, digit); end
      step();
    end
    v = exp_q.pop_front();
    for (int c = 0; c < FR; c++) begin
      ea = exp_an_f(c, v, dig_en);
      checks++;
      if (an !== ea) begin failures++; $display("FAIL load_an c=%0d actual=%h required=%h", c, an, ea); end
      checks++;
      if (digit !== exp_dig_f(c, v)) begin
        failures++; $display("FAIL load_digit c=%0d actual=%h required=%h", c, digit, exp_dig_f(c, v));
      end
      checks++;
      if (frame_tick !== (c == 0)) begin failures++; $display("FAIL load_tick c=%0d actual=%b required=%b", c, frame_tick, (c == 0)); end
      step();
    end
  endtask

  task automatic test_boundary();
    logic [15:0] v;
    logic [3:0] ea;
    repeat (FR - 1) step();
    value = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'h1234);
    for (int f = 0; f < 2; f++) begin
      v = exp_q.pop_front();
      for (int c = 0; c < FR; c++) begin
        ea = exp_an_f(c, v, dig_en);
        checks++;
        if (an !== ea) begin failures++; $display("FAIL bnd_an f=%0d c=%0d actual=%h required=%h", f, c, an, ea); end
        checks++;
        if (digit !== exp_dig_f(c, v)) begin
          failures++; $display("FAIL bnd_digit f=%0d c=%0d actual=%h required=%h", f, c, digit, exp_dig_f(c, v));
        end
        checks++;
        if (frame_tick !== (c == 0)) begin failures++; $display("FAIL bnd_tick f=%0d c=%0d actual=%b required=%b", f, c, frame_tick, (c == 0)); end
        step();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic [3:0] ea;
    value = 16'h1111; load = 1'b1;
    step();
    value = 16'h5A5A;
    step();
    load = 1'b0;
    exp_q.push_back(16'h5A5A);
    repeat (FR - 2) step();
    v = exp_q.pop_front();
    for (int c = 0; c < FR; c++) begin
      ea = exp_an_f(c, v, dig_en);
      checks++;
      if (an !== ea) begin failures++; $display("FAIL b2b_an c=%0d actual=%h required=%h", c, an, ea); end
      checks++;
      if (digit !== exp_dig_f(c, v)) begin
        failures++; $display("FAIL b2b_digit c=%0d actual=%h required=%h", c, digit, exp_dig_f(c, v));
      end
      step();
    end
  endtask

  task automatic test_mask();
    logic [15:0] v;
    logic [3:0] ea;
    dig_en = 4'b0101;
    exp_q.push_back(16'h5A5A);
    v = exp_q.pop_front();
    for (int c = 0; c < FR; c++) begin
      ea = exp_an_f(c, v, 4'b0101);
      checks++;
      if (an !== ea) begin failures++; $display("FAIL mask_an c=%0d actual=%h required=%h", c, an, ea); end
      checks++;
      if (an[1] !== 1'b1 || an[3] !== 1'b1) begin failures++; $display("FAIL mask_off c=%0d actual=%h required=1x1x", c, an); end
      step();
    end
    dig_en = 4'hF;
  endtask

  task automatic test_blank();
    logic [15:0] v;
    logic [3:0] ea;
    for (int f = 0; f < 2; f++) begin
      value = (f == 0) ? 16'h0042 : 16'h0000;
      load  = 1'b1;
      exp_q.push_back(value);
      step();
      load = 1'b0;
      repeat (FR - 1) step();
      v = exp_q.pop_front();
      for (int c = 0; c < FR; c++) begin
        ea = exp_an_f(c, v, dig_en);
        checks++;
        if (an !== ea) begin failures++; $display("FAIL blank_an v=%h c=%0d actual=%h required=%h", v, c, an, ea); end
        checks++;
        if (digit !== exp_dig_f(c, v)) begin
          failures++; $display("FAIL blank_digit v=%h c=%0d actual=%h required=%h", v, c, digit, exp_dig_f(c, v));
        end
        step();
      end
    end
  endtask

  task automatic test_midreset();
    logic [3:0] ea;
    value = 16'h9876; load = 1'b1;
    step();
    load = 1'b0;
    repeat (FR - 1) step();
    repeat (2 * RD + 2) step();
    checks++;
    if (an !== 4'hB || digit !== 4'h8) begin
      failures++; $display("FAIL pre_reset an=%h digit=%h required an=b digit=8", an, digit);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF) begin failures++; $display("FAIL async_an actual=%h required=f", an); end
    checks++;
    if (digit !== 4'h0) begin failures++; $display("FAIL async_digit actual=%h required=0", digit); end
    repeat (3) step();
    rst_n = 1'b1;
    for (int c = 0; c < FR + RD; c++) begin
      ea = exp_an_f(c, 16'h0000, 4'hF);
      checks++;
      if (an !== ea) begin failures++; $display("FAIL rst_scan_an c=%0d actual=%h required=%h", c, an, ea); end
      checks++;
      if (digit !== 4'h0) begin failures++; $display("FAIL rst_scan_digit c=%0d actual=%h required=0", c, digit); end
      checks++;
      if (frame_tick !== (c == FR)) begin
        failures++; $display("FAIL rst_scan_tick c=%0d actual=%b required=%b", c, frame_tick, (c == FR));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_boundary();
    test_back_to_back();
    test_mask();
    test_blank();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
